// File: rtl/my_mem_param_if.sv
// ============================================================================
// Module   : my_mem_param_if
// Brief    : Write/read/address/data bus plus error reporting for my_mem_param.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface my_mem_param_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 16,
    parameter int ERR_CNT_WIDTH = 16
);
    logic                     write;
    logic                     read;
    logic [ADDR_WIDTH-1:0]    address;
    logic [DATA_WIDTH-1:0]    data_in;
    logic                     inject_err;
    logic                     err_clear;
    logic [DATA_WIDTH:0]      data_out;
    logic                     rd_valid;
    logic                     parity_err;
    logic                     err_sticky;
    logic [ERR_CNT_WIDTH-1:0] err_count;

    modport master (
        output write, read, address, data_in, inject_err, err_clear,
        input  data_out, rd_valid, parity_err, err_sticky, err_count
    );

    modport slave (
        input  write, read, address, data_in, inject_err, err_clear,
        output data_out, rd_valid, parity_err, err_sticky, err_count
    );
endinterface

`default_nettype wire

// File: rtl/my_mem_param.sv
// ============================================================================
// Module   : my_mem_param
// Brief    : Single-port parity-protected RAM with configurable read latency.
// Revision : 1.0
// ============================================================================
`default_nettype none

module my_mem_param #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 16,
    parameter int READ_LATENCY  = 1,
    parameter int PARITY_ODD    = 0,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic          clk,
    input  logic          reset,
    my_mem_param_if.slave bus
);
    localparam int   c_DEPTH = 2 ** ADDR_WIDTH;
    localparam logic c_ODD   = 1'(PARITY_ODD != 0);

    generate
        if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
            $fatal(1, "my_mem_param: READ_LATENCY must be within 1..4");
        end
        if (DATA_WIDTH < 1 || DATA_WIDTH > 64) begin : g_bad_width
            $fatal(1, "my_mem_param: DATA_WIDTH must be within 1..64");
        end
    endgenerate

    logic [DATA_WIDTH:0]      r_mem [c_DEPTH];
    logic [DATA_WIDTH:0]      r_pipe_word [READ_LATENCY];
    logic [READ_LATENCY-1:0]  r_pipe_vld;
    logic [DATA_WIDTH:0]      r_data_out;
    logic                     r_rd_valid;
    logic                     r_parity_err;
    logic                     r_err_sticky;
    logic [ERR_CNT_WIDTH-1:0] r_err_count;

    logic                     w_wr_parity;
    logic [DATA_WIDTH:0]      w_last_word;
    logic                     w_last_vld;
    logic                     w_last_bad;

    assign w_wr_parity = (^bus.data_in) ^ c_ODD;

    // Array and read-data stages carry no reset so the array maps onto block RAM;
    // the read sees the pre-write word because both use non-blocking updates.
    always_ff @(posedge clk) begin
        if (bus.write) begin
            r_mem[bus.address] <= {w_wr_parity ^ bus.inject_err, bus.data_in};
        end
        if (bus.read) begin
            r_pipe_word[0] <= r_mem[bus.address];
        end
        for (int k = 1; k < READ_LATENCY; k++) begin
            r_pipe_word[k] <= r_pipe_word[k-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pipe_vld <= '0;
        end else begin
            r_pipe_vld[0] <= bus.read;
            for (int k = 1; k < READ_LATENCY; k++) begin
                r_pipe_vld[k] <= r_pipe_vld[k-1];
            end
        end
    end

    assign w_last_word = r_pipe_word[READ_LATENCY-1];
    assign w_last_vld  = r_pipe_vld[READ_LATENCY-1];
    assign w_last_bad  = ((^w_last_word[DATA_WIDTH-1:0]) ^ c_ODD) != w_last_word[DATA_WIDTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data_out   <= '0;
            r_rd_valid   <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_rd_valid   <= w_last_vld;
            r_parity_err <= w_last_vld & w_last_bad;
            if (w_last_vld) begin
                r_data_out <= w_last_word;
            end
        end
    end

    // A clear in the same cycle as a parity_err pulse swallows that error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_sticky <= 1'b0;
            r_err_count  <= '0;
        end else if (bus.err_clear) begin
            r_err_sticky <= 1'b0;
            r_err_count  <= '0;
        end else if (r_parity_err) begin
            r_err_sticky <= 1'b1;
            if (r_err_count != '1) begin
                r_err_count <= r_err_count + 1'b1;
            end
        end
    end

    assign bus.data_out   = r_data_out;
    assign bus.rd_valid   = r_rd_valid;
    assign bus.parity_err = r_parity_err;
    assign bus.err_sticky = r_err_sticky;
    assign bus.err_count  = r_err_count;

endmodule

`default_nettype wire

// File: tb/tb_my_mem_param.sv
// ============================================================================
// Module   : tb_my_mem_param
// Brief    : Three parameterisations of my_mem_param checked against a cycle model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_my_mem_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Per-instance stimulus: 0 = defaults, 1 = latency 3 / 2-bit counter, 2 = latency 2 / odd parity
    logic        rstv [3];
    logic        wr   [3];
    logic        rd   [3];
    logic        inj  [3];
    logic        clr  [3];
    logic [15:0] addr [3];
    logic [7:0]  din  [3];

    logic [8:0]  o_dout [3];
    logic        o_vld  [3];
    logic        o_perr [3];
    logic        o_st   [3];
    logic [15:0] o_cnt  [3];

    my_mem_param_if #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .ERR_CNT_WIDTH(16)) if_a ();
    my_mem_param_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8),  .ERR_CNT_WIDTH(2))  if_b ();
    my_mem_param_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8),  .ERR_CNT_WIDTH(16)) if_c ();

    my_mem_param #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .READ_LATENCY(1), .PARITY_ODD(0), .ERR_CNT_WIDTH(16))
        u_a (.clk(clk), .reset(rstv[0]), .bus(if_a.slave));
    my_mem_param #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .READ_LATENCY(3), .PARITY_ODD(0), .ERR_CNT_WIDTH(2))
        u_b (.clk(clk), .reset(rstv[1]), .bus(if_b.slave));
    my_mem_param #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .READ_LATENCY(2), .PARITY_ODD(1), .ERR_CNT_WIDTH(16))
        u_c (.clk(clk), .reset(rstv[2]), .bus(if_c.slave));

    assign if_a.write = wr[0];  assign if_a.read = rd[0];  assign if_a.address = addr[0];
    assign if_a.data_in = din[0];  assign if_a.inject_err = inj[0];  assign if_a.err_clear = clr[0];
    assign if_b.write = wr[1];  assign if_b.read = rd[1];  assign if_b.address = addr[1][7:0];
    assign if_b.data_in = din[1];  assign if_b.inject_err = inj[1];  assign if_b.err_clear = clr[1];
    assign if_c.write = wr[2];  assign if_c.read = rd[2];  assign if_c.address = addr[2][7:0];
    assign if_c.data_in = din[2];  assign if_c.inject_err = inj[2];  assign if_c.err_clear = clr[2];

    assign o_dout[0] = if_a.data_out;  assign o_vld[0] = if_a.rd_valid;  assign o_perr[0] = if_a.parity_err;
    assign o_st[0] = if_a.err_sticky;  assign o_cnt[0] = if_a.err_count;
    assign o_dout[1] = if_b.data_out;  assign o_vld[1] = if_b.rd_valid;  assign o_perr[1] = if_b.parity_err;
    assign o_st[1] = if_b.err_sticky;  assign o_cnt[1] = {14'd0, if_b.err_count};
    assign o_dout[2] = if_c.data_out;  assign o_vld[2] = if_c.rd_valid;  assign o_perr[2] = if_c.parity_err;
    assign o_st[2] = if_c.err_sticky;  assign o_cnt[2] = if_c.err_count;

    // Reference model: configuration, memory contents and results due at a given edge
    int          lat     [3] = '{1, 3, 2};
    int          cnt_max [3] = '{65535, 3, 65535};
    bit          odd     [3] = '{1'b0, 1'b0, 1'b1};
    logic [15:0] amask   [3] = '{16'hFFFF, 16'h00FF, 16'h00FF};

    logic [8:0]  m_mem  [int];
    logic [8:0]  m_pend [int];
    logic [8:0]  m_dout [3];
    bit          m_vld  [3];
    bit          m_perr [3];
    bit          m_st   [3];
    int          m_cnt  [3];
    int          edge_n = 0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic bit par(input logic [7:0] d, input bit is_odd);
        return (($countones(d) % 2) == 1) ^ is_odd;
    endfunction

    task automatic model_reset(input int i);
        m_dout[i] = '0;
        m_vld[i]  = 1'b0;
        m_perr[i] = 1'b0;
        m_st[i]   = 1'b0;
        m_cnt[i]  = 0;
        for (int d = 0; d <= 5; d++) begin
            if (m_pend.exists(i * (1 << 20) + edge_n + d)) m_pend.delete(i * (1 << 20) + edge_n + d);
        end
    endtask

    task automatic model_edge(input int i);
        int key;
        if (rstv[i]) begin
            model_reset(i);
            return;
        end
        if (clr[i]) begin
            m_st[i]  = 1'b0;
            m_cnt[i] = 0;
        end else if (m_perr[i]) begin
            m_st[i] = 1'b1;
            if (m_cnt[i] < cnt_max[i]) m_cnt[i]++;
        end
        key = i * 65536 + int'(addr[i] & amask[i]);
        if (rd[i]) m_pend[i * (1 << 20) + edge_n + lat[i]] = m_mem[key];
        if (wr[i]) m_mem[key] = {par(din[i], odd[i]) ^ inj[i], din[i]};
        key = i * (1 << 20) + edge_n;
        if (m_pend.exists(key)) begin
            m_vld[i]  = 1'b1;
            m_dout[i] = m_pend[key];
            m_perr[i] = par(m_dout[i][7:0], odd[i]) != m_dout[i][8];
            m_pend.delete(key);
        end else begin
            m_vld[i]  = 1'b0;
            m_perr[i] = 1'b0;
        end
    endtask

    task automatic compare(input int i);
        chk($sformatf("i%0d e%0d rd_valid", i, edge_n), 32'(o_vld[i]), 32'(m_vld[i]));
        chk($sformatf("i%0d e%0d parity_err", i, edge_n), 32'(o_perr[i]), 32'(m_perr[i]));
        chk($sformatf("i%0d e%0d data_out", i, edge_n), 32'(o_dout[i]), 32'(m_dout[i]));
        chk($sformatf("i%0d e%0d err_sticky", i, edge_n), 32'(o_st[i]), 32'(m_st[i]));
        chk($sformatf("i%0d e%0d err_count", i, edge_n), 32'(o_cnt[i]), 32'(m_cnt[i]));
    endtask

    task automatic step();
        for (int i = 0; i < 3; i++) model_edge(i);
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) compare(i);
        edge_n++;
    endtask

    task automatic idle_all();
        for (int i = 0; i < 3; i++) begin
            wr[i] = 0; rd[i] = 0; inj[i] = 0; clr[i] = 0; addr[i] = '0; din[i] = '0;
        end
    endtask

    typedef struct {
        bit          w;
        bit          r;
        logic [15:0] a;
        logic [7:0]  d;
        bit          ij;
        bit          cl;
        bit          ev;
        logic [8:0]  edo;
        bit          ep;
        bit          es;
        int          ec;
    } vec_t;

    vec_t        tbl [13];
    logic [8:0]  burst_exp [4];
    int          cnt_exp [5];
    logic [15:0] pool [3][6];
    int          perm [6];

    initial begin
        // {write, read, address, data, inject, clear | valid, data_out, parity_err, sticky, count}
        tbl[0]  = '{1, 0, 16'h0040, 8'h11, 0, 0, 0, 9'h000, 0, 0, 0};
        tbl[1]  = '{1, 1, 16'h0040, 8'h22, 0, 0, 0, 9'h000, 0, 0, 0};
        tbl[2]  = '{0, 1, 16'h0040, 8'h00, 0, 0, 1, 9'h011, 0, 0, 0};
        tbl[3]  = '{1, 0, 16'h00A5, 8'hA5, 0, 0, 1, 9'h022, 0, 0, 0};
        tbl[4]  = '{1, 0, 16'h0007, 8'h07, 0, 0, 0, 9'h022, 0, 0, 0};
        tbl[5]  = '{0, 1, 16'h00A5, 8'h00, 0, 0, 0, 9'h022, 0, 0, 0};
        tbl[6]  = '{0, 1, 16'h0007, 8'h00, 0, 0, 1, 9'h0A5, 0, 0, 0};
        tbl[7]  = '{0, 0, 16'h0000, 8'h00, 0, 0, 1, 9'h107, 0, 0, 0};
        tbl[8]  = '{1, 0, 16'h1234, 8'h3C, 1, 0, 0, 9'h107, 0, 0, 0};
        tbl[9]  = '{0, 1, 16'h1234, 8'h00, 0, 0, 0, 9'h107, 0, 0, 0};
        tbl[10] = '{0, 0, 16'h0000, 8'h00, 0, 0, 1, 9'h13C, 1, 0, 0};
        tbl[11] = '{0, 0, 16'h0000, 8'h00, 0, 0, 0, 9'h13C, 0, 1, 1};
        tbl[12] = '{0, 0, 16'h0000, 8'h00, 0, 1, 0, 9'h13C, 0, 0, 0};
        burst_exp = '{9'h081, 9'h082, 9'h183, 9'h084};
        cnt_exp   = '{1, 2, 3, 3, 3};

        idle_all();
        for (int i = 0; i < 3; i++) begin
            rstv[i] = 1'b1;
            model_reset(i);
        end
        step();
        step();
        for (int i = 0; i < 3; i++) rstv[i] = 1'b0;
        step();

        // Default instance: directed vectors incl. read-first collision and injected error
        for (int k = 0; k < 13; k++) begin
            idle_all();
            wr[0] = tbl[k].w; rd[0] = tbl[k].r; addr[0] = tbl[k].a;
            din[0] = tbl[k].d; inj[0] = tbl[k].ij; clr[0] = tbl[k].cl;
            step();
            chk($sformatf("vec%0d rd_valid", k), 32'(o_vld[0]), 32'(tbl[k].ev));
            chk($sformatf("vec%0d data_out", k), 32'(o_dout[0]), 32'(tbl[k].edo));
            chk($sformatf("vec%0d parity_err", k), 32'(o_perr[0]), 32'(tbl[k].ep));
            chk($sformatf("vec%0d err_sticky", k), 32'(o_st[0]), 32'(tbl[k].es));
            chk($sformatf("vec%0d err_count", k), 32'(o_cnt[0]), 32'(tbl[k].ec));
        end
        idle_all();

        // Latency 3: four back-to-back reads emerge on four consecutive cycles
        for (int k = 0; k < 4; k++) begin
            idle_all();
            wr[1] = 1; addr[1] = 16'(k + 1); din[1] = 8'(8'h81 + k);
            step();
        end
        for (int k = 0; k < 8; k++) begin
            idle_all();
            rd[1] = (k < 4); addr[1] = 16'(k + 1);
            step();
            chk($sformatf("burst%0d rd_valid", k), 32'(o_vld[1]), 32'(k >= 3 && k <= 6));
            if (k >= 3 && k <= 6)
                chk($sformatf("burst%0d data_out", k), 32'(o_dout[1]), 32'(burst_exp[k-3]));
        end

        // 2-bit counter saturates; then clear coinciding with parity_err wins
        idle_all();
        wr[1] = 1; addr[1] = 16'h0010; din[1] = 8'h3C; inj[1] = 1;
        step();
        for (int k = 0; k < 9; k++) begin
            idle_all();
            rd[1] = (k < 5); addr[1] = 16'h0010;
            step();
            if (k >= 4) begin
                chk($sformatf("sat%0d err_count", k), 32'(o_cnt[1]), 32'(cnt_exp[k-4]));
                chk($sformatf("sat%0d err_sticky", k), 32'(o_st[1]), 32'd1);
            end
        end
        idle_all(); clr[1] = 1; step();
        idle_all(); rd[1] = 1; addr[1] = 16'h0010; step();
        idle_all(); step(); step(); step();
        chk("clrsame parity_err", 32'(o_perr[1]), 32'd1);
        clr[1] = 1; step();
        chk("clrsame err_count", 32'(o_cnt[1]), 32'd0);
        chk("clrsame err_sticky", 32'(o_st[1]), 32'd0);
        idle_all(); step();
        chk("clrsame after count", 32'(o_cnt[1]), 32'd0);

        // Latency 2 odd parity: reset while a read is in flight
        idle_all(); wr[2] = 1; addr[2] = 16'h0005; din[2] = 8'h5A; step();
        idle_all(); wr[2] = 1; addr[2] = 16'h0006; din[2] = 8'h33; inj[2] = 1; step();
        idle_all(); rd[2] = 1; addr[2] = 16'h0006; step();
        idle_all(); step(); step(); step();
        chk("pre-reset err_sticky", 32'(o_st[2]), 32'd1);
        rd[2] = 1; addr[2] = 16'h0005; step();
        idle_all();
        rstv[2] = 1'b1;
        model_reset(2);
        #1;
        chk("async data_out", 32'(o_dout[2]), 32'd0);
        chk("async rd_valid", 32'(o_vld[2]), 32'd0);
        chk("async err_sticky", 32'(o_st[2]), 32'd0);
        chk("async err_count", 32'(o_cnt[2]), 32'd0);
        step();
        rstv[2] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("post-reset%0d rd_valid", k), 32'(o_vld[2]), 32'd0);
        end
        rd[2] = 1; addr[2] = 16'h0005; step();
        idle_all(); step(); step();
        chk("survive rd_valid", 32'(o_vld[2]), 32'd1);
        chk("survive data_out", 32'(o_dout[2]), 32'h15A);

        // Random: fill a pool, read back shuffled, then mixed traffic
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 3; i++) begin
                pool[i][k] = 16'($urandom) & amask[i];
                wr[i] = 1; rd[i] = 0; addr[i] = pool[i][k]; din[i] = 8'($urandom);
            end
            step();
        end
        for (int k = 0; k < 6; k++) perm[k] = k;
        for (int k = 5; k > 0; k--) begin
            int j, t;
            j = int'($urandom_range(k, 0));
            t = perm[k]; perm[k] = perm[j]; perm[j] = t;
        end
        for (int k = 0; k < 6; k++) begin
            idle_all();
            for (int i = 0; i < 3; i++) begin
                rd[i] = 1; addr[i] = pool[i][perm[k]];
            end
            step();
        end
        idle_all();
        for (int k = 0; k < 4; k++) step();
        for (int i = 0; i < 3; i++)
            chk($sformatf("shuffle i%0d err_count", i), 32'(o_cnt[i]), 32'(m_cnt[i]));
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 3; i++) begin
                rd[i]   = 1'($urandom_range(1, 0));
                wr[i]   = ($urandom_range(2, 0) == 0);
                addr[i] = pool[i][$urandom_range(5, 0)];
                din[i]  = 8'($urandom);
                inj[i]  = ($urandom_range(7, 0) == 0);
                clr[i]  = ($urandom_range(15, 0) == 0);
            end
            step();
        end
        idle_all();
        for (int k = 0; k < 5; k++) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
